// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state type, one-hot op encodings and operand width helper
// for calc_seq_engine.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIN,
    ST_EXEC,
    ST_CONV,
    ST_SHOW
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1000;

  // Bits needed to hold 10^digits - 1.
  function automatic int unsigned opw_bits(input int unsigned digits);
    int unsigned lim;
    int unsigned bits;
    lim = 1;
    for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
    lim  = lim - 1;
    bits = 0;
    while (lim != 0) begin
      bits++;
      lim = lim >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle, BIN_W cycles after start_i.
// done_o marks the final step; bcd_o carries the stepped value, valid alongside done_o.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      {bcd_d, sh_d} = {adj, sh_q} << 1;
      cnt_d         = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = !start_i && (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_d;

endmodule

// File: rtl/calc_seq_engine.sv
// calc_seq_engine: BCD digit-entry calculator with sequential BIN/EXEC/CONV datapath.
// Divider built only when CALC_DIV_EN is defined; otherwise divide is rejected as an illegal op.
module calc_seq_engine
  import calc_pkg::*;
#(
  parameter int unsigned OPD_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tick,
  input  logic [2*OPD_DIGITS-1:0] inc,
  input  logic [3:0]              op,
  input  logic                    start,
  input  logic                    original,
  output logic [8*OPD_DIGITS-1:0] disp_bcd,
  output logic                    neg,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned OPW         = opw_bits(OPD_DIGITS);
  localparam int unsigned RES_W       = 2 * OPW;
  localparam int unsigned DISP_DIGITS = 2 * OPD_DIGITS;
  localparam int unsigned DISP_W      = 4 * DISP_DIGITS;
  localparam int unsigned CNT_W       = $clog2(OPW + 1);

  state_e                 state_q, state_d;
  logic [DISP_W-1:0]      digs_q, digs_d, res_q, res_d, conv_bcd;
  logic [DISP_DIGITS-1:0] hist_q, hist_d, inc_rise;
  logic [3:0]             op_q, op_d, a_dig, b_dig;
  logic [OPW-1:0]         a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_q, neg_d, negp_q, negp_d, err_q, err_d, done_q, done_d;
  logic                   start_ok, op_legal, exec_last, mul_bit, conv_start, conv_done;
`ifdef CALC_DIV_EN
  logic [OPW-1:0]         rem_q, rem_d;
  logic [OPW:0]           rem_sh;
  logic                   a_bit;

  assign a_bit  = |(a_q & (OPW'(1) << (CNT_W'(OPW - 1) - cnt_q)));
  assign rem_sh = {rem_q, a_bit};
  assign op_legal = (op == OP_ADD) || (op == OP_MUL) || (op == OP_SUB) || (op == OP_DIV);
`else
  assign op_legal = (op == OP_ADD) || (op == OP_MUL) || (op == OP_SUB);
`endif

  assign busy     = (state_q == ST_BIN) || (state_q == ST_EXEC) || (state_q == ST_CONV);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_SHOW));
  assign mul_bit  = |(b_q & (OPW'(1) << cnt_q));

  // History follows inc on every tick, even while busy, so held presses are not replayed later.
  always_comb begin
    hist_d   = tick ? inc : hist_q;
    inc_rise = tick ? (inc & ~hist_q) : '0;
    digs_d   = digs_q;
    if (!busy) begin
      for (int unsigned i = 0; i < DISP_DIGITS; i++) begin
        if (inc_rise[i])
          digs_d[4*i +: 4] = (digs_q[4*i +: 4] == 4'd9) ? 4'd0 : digs_q[4*i +: 4] + 4'd1;
      end
    end
  end

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < OPD_DIGITS; i++) begin
      if (cnt_q == CNT_W'(OPD_DIGITS - 1 - i)) begin
        a_dig = digs_q[4*i +: 4];
        b_dig = digs_q[4*(OPD_DIGITS + i) +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    neg_d      = neg_q;
    negp_d     = negp_q;
    err_d      = err_q;
    done_d     = 1'b0;
    exec_last  = 1'b0;
    conv_start = 1'b0;
`ifdef CALC_DIV_EN
    rem_d      = rem_q;
`endif
    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (start_ok) begin
          op_d   = op;
          a_d    = '0;
          b_d    = '0;
          acc_d  = '0;
          cnt_d  = '0;
          neg_d  = 1'b0;
          negp_d = 1'b0;
          err_d  = 1'b0;
`ifdef CALC_DIV_EN
          rem_d  = '0;
`endif
          if (op_legal) begin
            state_d = ST_BIN;
          end else begin
            err_d   = 1'b1;
            res_d   = '0;
            done_d  = 1'b1;
            state_d = ST_SHOW;
          end
        end else if ((state_q == ST_SHOW) && (|inc_rise)) begin
          state_d = ST_IDLE;
          res_d   = '0;
          neg_d   = 1'b0;
        end
      end
      ST_BIN: begin
        a_d   = a_q * OPW'(10) + OPW'(a_dig);
        b_d   = b_q * OPW'(10) + OPW'(b_dig);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OPD_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_last = 1'b1;
        case (op_q)
          OP_ADD: acc_d = RES_W'(a_q) + RES_W'(b_q);
          OP_SUB: begin
            if (a_q < b_q) begin
              acc_d  = RES_W'(b_q) - RES_W'(a_q);
              negp_d = 1'b1;
            end else begin
              acc_d  = RES_W'(a_q) - RES_W'(b_q);
            end
          end
          OP_MUL: begin
            if (mul_bit) acc_d = acc_q + (RES_W'(a_q) << cnt_q);
            exec_last = (cnt_q == CNT_W'(OPW - 1));
          end
`ifdef CALC_DIV_EN
          // Restoring divide: quotient bits shift into acc from the LSB, MSB of A first.
          OP_DIV: begin
            if (b_q == '0) begin
              err_d = 1'b1;
              acc_d = '0;
            end else begin
              acc_d = {acc_q[RES_W-2:0], 1'b0};
              rem_d = rem_sh[OPW-1:0];
              if (rem_sh >= {1'b0, b_q}) begin
                rem_d    = OPW'(rem_sh - {1'b0, b_q});
                acc_d[0] = 1'b1;
              end
              exec_last = (cnt_q == CNT_W'(OPW - 1));
            end
          end
`endif
          default: acc_d = '0;
        endcase
        cnt_d = cnt_q + 1'b1;
        if (exec_last) begin
          cnt_d      = '0;
          conv_start = 1'b1;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          res_d   = conv_bcd;
          neg_d   = negp_q;
          done_d  = 1'b1;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bin2bcd_seq #(
    .BIN_W (RES_W),
    .DIGITS(DISP_DIGITS)
  ) u_conv (
    .clk_i  (clk),
    .rst_ni (rstn),
    .start_i(conv_start),
    .bin_i  (acc_d),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      digs_q  <= '0;
      hist_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      negp_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      digs_q  <= digs_d;
      hist_q  <= hist_d;
      res_q   <= res_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      negp_q  <= negp_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef CALC_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign disp_bcd = ((state_q == ST_SHOW) && !original) ? res_q : digs_q;
  assign neg      = neg_q & ~original;
  assign done     = done_q;
  assign err      = err_q;

endmodule
